rng_byte_scheduler: RTL
=======================

// Module: rng_byte_scheduler
// PURPOSE
//  Sits behind the parity filter and owns its filtered bit stream.
//  - Packs filtered bits into bytes and discards warm-up bytes.
//  - Runs a repetition health test on completed bytes.
//  - Buffers bytes in a small FIFO.
//  - Shares them among NUM_REQ requesters with round-robin arbitration.
// PARAMETERS
//  NUM_REQ      4  number of requesters (>=2)
//  FIFO_DEPTH   4  byte FIFO entries (power of 2, >=2)
//  REP_LIMIT    4  consecutive identical bytes that trip the fault (>=2)
//  WARMUP_BYTES 2  completed bytes discarded after reset or fault clear
// PORTS
//  high_Freq_Clk in  1                    single clock, rising edge
//  reset         in  1                    synchronous, active-high
//  bit_In        in  1                    filtered random bit
//  bit_Valid     in  1                    bit_In valid this cycle
//  req           in  NUM_REQ              request per requester, level
//  fault_Clear   in  1                    leave FAULT (1-cycle pulse)
//  grant         out NUM_REQ              one-hot, 1-cycle grant
//  random_Byte   out 8                    byte delivered with grant
//  byte_Valid    out 1                    high when grant != 0
//  fifo_Level    out $clog2(FIFO_DEPTH)+1 occupied entries
//  fault         out 1                    health test tripped
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values:
//   - all outputs 0; state WARMUP; bit/warm-up/repetition counters 0.
//   - round-robin pointer set so req[0] has first priority.
//  Assembler:
//   - each bit_Valid shifts bit_In in LSB-first.
//   - 8th bit completes a byte, visible internally the same edge.
//   - keeps running in every state.
//  Health test (WARMUP and RUN):
//   - completed byte == previous completed byte -> rep count +1, else reset to 1.
//   - count reaching REP_LIMIT -> FAULT on the same edge.
//  State machine:
//   - WARMUP: drop completed bytes; after WARMUP_BYTES of them -> RUN.
//   - RUN: push completed bytes to FIFO; arbitrate.
//   - FAULT: fault=1; FIFO flushed (fifo_Level=0) on entry; no grants.
//     Completed bytes dropped. fault_Clear -> WARMUP, counters zeroed.
//   - fault_Clear outside FAULT is ignored.
//  Arbitration (RUN only):
//   - if FIFO non-empty and req != 0 at edge k: grant = winner at k+1 for one cycle.
//   - random_Byte = FIFO head, byte_Valid=1, head popped.
//   - winner = first asserted req searching from last winner+1, wrapping.
//   - max one grant per cycle; back-to-back grants allowed.
//   - random_Byte holds last delivered value between grants.
//   - requester holds req until granted; a dropped req is not remembered.
//  Boundaries:
//   - push into full FIFO with no pop: byte dropped, level unchanged.
//   - push + pop same cycle: both happen, level unchanged, even when full.
//   - no empty bypass: byte pushed at edge k can be granted at k+1 at earliest.
//   - fault trip and grant in same cycle: fault wins, no grant.
//   - reset mid-byte or mid-FAULT: everything returns to reset values;
//     partial byte discarded.
//   - FIFO pointers wrap modulo FIFO_DEPTH; level saturates at FIFO_DEPTH.
// TESTING
//  1. Reset, then 24 valid bits forming 0x11,0x22,0x33 -> 0x11,0x22 dropped;
//     fifo_Level=1; head=0x33.
//  2. FIFO holds A0,A1,A2,A3; req=4'b1111 held -> grant 0001,0010,0100,1000
//     on 4 consecutive cycles; random_Byte A0..A3; fifo_Level 0.
//  3. FIFO full (4), byte completes with req=0 -> dropped, level 4.
//     Repeat with req=0001 -> pop and push same edge, level stays 4.
//  4. Four consecutive 0xA5 bytes -> fault=1 at 4th completion, fifo_Level=0,
//     no grants with req=1111. fault_Clear pulse -> fault=0; next 2 bytes dropped.
//  5. Reset asserted after 5 bits of a byte -> next 8 bits form a fresh byte;
//     first two completed bytes dropped as warm-up.
//  6. req=0100 with FIFO empty -> no grant. Byte pushed at edge k ->
//     grant=0100 at k+1 only; grant=0 at k+2.

Source files
------------

// File: rtl/rng_byte_scheduler_if.sv
// Bundles the bit-stream input, the requester handshake and the status outputs
// of rng_byte_scheduler so they travel as one port.
// master = the environment driving bits/requests, slave = the scheduler itself.
interface rng_byte_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 4
);
   logic                          bit_In;
   logic                          bit_Valid;
   logic [NUM_REQ-1:0]            req;
   logic                          fault_Clear;
   logic [NUM_REQ-1:0]            grant;
   logic [7:0]                    random_Byte;
   logic                          byte_Valid;
   logic [$clog2(FIFO_DEPTH):0]   fifo_Level;
   logic                          fault;

   modport master (
      output bit_In, bit_Valid, req, fault_Clear,
      input  grant, random_Byte, byte_Valid, fifo_Level, fault
   );

   modport slave (
      input  bit_In, bit_Valid, req, fault_Clear,
      output grant, random_Byte, byte_Valid, fifo_Level, fault
   );
endinterface

// File: rtl/rng_byte_scheduler.sv
// Packs filtered bits into bytes, runs a repetition health test, buffers bytes and shares them round-robin.
// Latency: a byte pushed at edge k can be granted at edge k+1 at the earliest; grant/random_Byte are registered.
// Backpressure: none toward the bit source; a byte arriving at a full FIFO without a same-cycle pop is dropped.
module rng_byte_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int REP_LIMIT    = 4,
   parameter int WARMUP_BYTES = 2
) (
   input  logic                high_Freq_Clk,
   input  logic                reset,
   rng_byte_scheduler_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int REQ_W = $clog2(NUM_REQ);
   localparam int REP_W = $clog2(REP_LIMIT + 1);
   localparam int WU_W  = $clog2(WARMUP_BYTES + 1) + 1;

   typedef enum logic [1:0] { ST_WARMUP, ST_RUN, ST_FAULT } state_t;

   state_t             state_q,   state_d;
   logic [7:0]         shift_q,   shift_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         prev_q,    prev_d;
   logic [REP_W-1:0]   rep_q,     rep_d;
   logic [WU_W-1:0]    wu_q,      wu_d;
   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [7:0]         mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_q,      rd_d;
   logic [PTR_W-1:0]   wr_q,      wr_d;
   logic [LVL_W-1:0]   lvl_q,     lvl_d;
   logic [REQ_W-1:0]   last_q,    last_d;
   logic [NUM_REQ-1:0] grant_q,   grant_d;
   logic [7:0]         rbyte_q,   rbyte_d;
   logic               bvld_q,    bvld_d;
   logic               fault_q,   fault_d;

   logic               win_found;
   logic [REQ_W-1:0]   win_idx;
   int unsigned        idx;

   logic               byte_done;
   logic [7:0]         done_byte;
   logic [REP_W-1:0]   rep_next;
   logic               trip;
   logic               do_push;
   logic               do_pop;
   logic               push_ok;

   // Round-robin search: first asserted request after the last winner, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      idx       = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_q) + i) % NUM_REQ;
         if (!win_found && bus.req[REQ_W'(idx)]) begin
            win_found = 1'b1;
            win_idx   = REQ_W'(idx);
         end
      end
   end

   // Next-state: assembler, health test, mode control, FIFO and grant generation.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      prev_d    = prev_q;
      rep_d     = rep_q;
      wu_d      = wu_q;
      mem_d     = mem_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      lvl_d     = lvl_q;
      last_d    = last_q;
      grant_d   = '0;
      rbyte_d   = rbyte_q;
      bvld_d    = 1'b0;
      fault_d   = fault_q;
      byte_done = 1'b0;
      rep_next  = rep_q;
      trip      = 1'b0;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      push_ok   = 1'b0;

      // LSB-first: the first bit ends up in bit 0 after eight right shifts.
      done_byte = {bus.bit_In, shift_q[7:1]};
      if (bus.bit_Valid) begin
         shift_d   = done_byte;
         bit_cnt_d = bit_cnt_q + 3'd1;
         byte_done = (bit_cnt_q == 3'd7);
      end

      // rep_q == 0 means "no previous byte", so the first byte always counts as 1.
      if (byte_done && state_q != ST_FAULT) begin
         if (rep_q != '0 && done_byte == prev_q) begin
            rep_next = rep_q + REP_W'(1);
         end else begin
            rep_next = REP_W'(1);
         end
         rep_d  = rep_next;
         prev_d = done_byte;
         trip   = (rep_next == REP_W'(REP_LIMIT));
      end

      case (state_q)
         ST_WARMUP: begin
            if (trip) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
            end else if (byte_done) begin
               wu_d = wu_q + WU_W'(1);
               if (wu_q + WU_W'(1) == WU_W'(WARMUP_BYTES)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (trip) begin
               // Fault beats any grant this cycle and flushes the buffer.
               state_d = ST_FAULT;
               fault_d = 1'b1;
               rd_d    = '0;
               wr_d    = '0;
               lvl_d   = '0;
            end else begin
               do_push = byte_done;
               do_pop  = (lvl_q != '0) && win_found;
            end
         end
         ST_FAULT: begin
            if (bus.fault_Clear) begin
               state_d = ST_WARMUP;
               fault_d = 1'b0;
               wu_d    = '0;
               rep_d   = '0;
               prev_d  = '0;
            end
         end
         default: begin
            state_d = ST_WARMUP;
         end
      endcase

      // Pop decision uses the pre-edge level, so a byte pushed now waits a cycle.
      if (do_pop) begin
         grant_d = NUM_REQ'(1) << win_idx;
         rbyte_d = mem_q[rd_q];
         bvld_d  = 1'b1;
         rd_d    = rd_q + PTR_W'(1);
         last_d  = win_idx;
      end

      push_ok = do_push && ((lvl_q != LVL_W'(FIFO_DEPTH)) || do_pop);
      if (push_ok) begin
         mem_d[wr_q] = done_byte;
         wr_d        = wr_q + PTR_W'(1);
      end

      if (push_ok && !do_pop) begin
         lvl_d = lvl_q + LVL_W'(1);
      end else if (!push_ok && do_pop) begin
         lvl_d = lvl_q - LVL_W'(1);
      end
   end

   // State registers with synchronous reset; req[0] gets first priority after reset.
   always_ff @(posedge high_Freq_Clk) begin
      if (reset) begin
         state_q   <= ST_WARMUP;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         prev_q    <= '0;
         rep_q     <= '0;
         wu_q      <= '0;
         mem_q     <= '{default: '0};
         rd_q      <= '0;
         wr_q      <= '0;
         lvl_q     <= '0;
         last_q    <= REQ_W'(NUM_REQ - 1);
         grant_q   <= '0;
         rbyte_q   <= '0;
         bvld_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         prev_q    <= prev_d;
         rep_q     <= rep_d;
         wu_q      <= wu_d;
         mem_q     <= mem_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         lvl_q     <= lvl_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         rbyte_q   <= rbyte_d;
         bvld_q    <= bvld_d;
         fault_q   <= fault_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.random_Byte = rbyte_q;
   assign bus.byte_Valid  = bvld_q;
   assign bus.fifo_Level  = lvl_q;
   assign bus.fault       = fault_q;
endmodule
